gpuram_arb: RTL and testbench

Single-port arbiter and sequencer for the 1024x32 GPU local RAM in Tom.
- Shares the RAM between two requesters:
  - the GPU core port (instruction fetch and load/store);
  - the external bus port (host CPU, blitter or object-processor accesses mapped into GPU RAM).
- Drives the RAM address, enable, write-enable and write data.
- Returns one-cycle-latency read data to whichever requester issued the read.
- Guarantees the GPU core forward progress under sustained external traffic.

---
 rtl/gpuram_pkg.sv | 18 +
 rtl/gpuram_fair.sv | 58 +++++
 rtl/gpuram_arb.sv | 96 +++++++++
 tb/tb_gpuram_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpuram_pkg.sv
// Shared definitions for the GPU local RAM arbiter.
//   GPURAM_AW / GPURAM_DW : address and data width of the 1024x32 GPU RAM
//   GPURAM_MAXEXT         : default limit on consecutive external grants
//                           while a GPU request is waiting
//   gnt_e                 : grant code produced by the fairness block
package gpuram_pkg;

    localparam int GPURAM_AW     = 10;
    localparam int GPURAM_DW     = 32;
    localparam int GPURAM_MAXEXT = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_GPU  = 2'd1,
        GNT_EXT  = 2'd2
    } gnt_e;

endpackage

// File: rtl/gpuram_fair.sv
// Priority decision and starvation counter for the GPU RAM arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   gpu_req    : GPU core request
//   ext_req    : external bus request
//   gnt        : combinational grant code for this cycle (GNT_NONE while reset)
// External requests normally win a collision; after MAXEXT consecutive
// external wins against a waiting GPU request, the GPU is granted once.
module gpuram_fair
    import gpuram_pkg::*;
#(
    parameter int MAXEXT = GPURAM_MAXEXT
) (
    input  logic clk,
    input  logic reset,
    input  logic gpu_req,
    input  logic ext_req,
    output gnt_e gnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAXEXT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (gpu_req && ext_req) begin
                gnt = (starve_cnt_q < MAX_CNT) ? GNT_EXT : GNT_GPU;
            end else if (gpu_req) begin
                gnt = GNT_GPU;
            end else if (ext_req) begin
                gnt = GNT_EXT;
            end
        end
    end

    // The counter only measures how long the current GPU request has been
    // waiting, so any cycle without a GPU request, or a GPU win, restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!gpu_req || gnt == GNT_GPU) begin
            starve_cnt_d = 4'd0;
        end else if (gnt == GNT_EXT && starve_cnt_q < MAX_CNT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/gpuram_arb.sv
// Single-port arbiter/sequencer for the 1024x32 GPU local RAM.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   gpu_req/we/addr/wdata, gpu_ack  : GPU core request port, combinational ack
//   gpu_rvalid                      : GPU read data valid (cycle after grant)
//   ext_req/we/addr/wdata, ext_ack  : external bus request port, combinational ack
//   ext_rvalid                      : external read data valid (cycle after grant)
//   rdata                           : read data shared by both ports
//   rama, ramen, ramwe, ram_wdata   : RAM controls, sampled by the RAM on the rising edge
//   ram_rdata                       : RAM read data, valid the cycle after a read
module gpuram_arb
    import gpuram_pkg::*;
#(
    parameter int AW     = GPURAM_AW,
    parameter int DW     = GPURAM_DW,
    parameter int MAXEXT = GPURAM_MAXEXT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gpu_req,
    input  logic          gpu_we,
    input  logic [AW-1:0] gpu_addr,
    input  logic [DW-1:0] gpu_wdata,
    output logic          gpu_ack,
    output logic          gpu_rvalid,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic          ext_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rama,
    output logic          ramen,
    output logic          ramwe,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    gnt_e gnt;

    logic gpu_rvalid_q;
    logic gpu_rvalid_d;
    logic ext_rvalid_q;
    logic ext_rvalid_d;

    gpuram_fair #(
        .MAXEXT (MAXEXT)
    ) u_fair (
        .clk     (clk),
        .reset   (reset),
        .gpu_req (gpu_req),
        .ext_req (ext_req),
        .gnt     (gnt)
    );

    // RAM mux: the GPU port is the quiet default so the address/data bus
    // only toggles for external traffic when the external port actually wins.
    always_comb begin
        gpu_ack   = (gnt == GNT_GPU);
        ext_ack   = (gnt == GNT_EXT);
        ramen     = (gnt != GNT_NONE);
        rama      = gpu_addr;
        ram_wdata = gpu_wdata;
        ramwe     = 1'b0;
        if (gnt == GNT_EXT) begin
            rama      = ext_addr;
            ram_wdata = ext_wdata;
            ramwe     = ext_we;
        end else if (gnt == GNT_GPU) begin
            ramwe     = gpu_we;
        end
    end

    always_comb begin
        gpu_rvalid_d = gpu_ack && !gpu_we;
        ext_rvalid_d = ext_ack && !ext_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            gpu_rvalid_q <= gpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    // A read granted just before reset rises must not report its data, so
    // the valid flags are also masked during the reset cycle itself.
    assign gpu_rvalid = gpu_rvalid_q && !reset;
    assign ext_rvalid = ext_rvalid_q && !reset;
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_gpuram_arb.sv
// Self-checking bench for gpuram_arb: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// rule-level reference model (grant rules, waiting-count, memory image).
module tb_gpuram_arb;
    import gpuram_pkg::*;

    localparam int AW = GPURAM_AW;
    localparam int DW = GPURAM_DW;
    localparam int MX = GPURAM_MAXEXT;

    logic          clk = 1'b0;
    logic          reset;
    logic          gpu_req, gpu_we, ext_req, ext_we;
    logic [AW-1:0] gpu_addr, ext_addr;
    logic [DW-1:0] gpu_wdata, ext_wdata;
    logic          gpu_ack, gpu_rvalid, ext_ack, ext_rvalid;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] rama;
    logic          ramen, ramwe;

    int checks   = 0;
    int failures = 0;

    gpuram_arb #(.AW(AW), .DW(DW), .MAXEXT(MX)) dut (
        .clk        (clk),
        .reset      (reset),
        .gpu_req    (gpu_req),
        .gpu_we     (gpu_we),
        .gpu_addr   (gpu_addr),
        .gpu_wdata  (gpu_wdata),
        .gpu_ack    (gpu_ack),
        .gpu_rvalid (gpu_rvalid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rvalid (ext_rvalid),
        .rdata      (rdata),
        .rama       (rama),
        .ramen      (ramen),
        .ramwe      (ramwe),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM attached to the DUT
    bit [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (ramen) begin
            if (ramwe) ram[rama] <= ram_wdata;
            else       ram_rdata <= ram[rama];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          model_on = 1'b0;
    bit [DW-1:0] m_mem [1024];
    int          m_wait   = 0;     // consecutive external wins against a waiting GPU
    bit          pend_g   = 1'b0;
    bit          pend_e   = 1'b0;
    bit [DW-1:0] pend_data;
    int          eg;               // 0 none, 1 gpu, 2 ext
    bit          exp_we;
    bit [AW-1:0] exp_a;
    bit [DW-1:0] exp_wd;

    always @(negedge clk) begin
        if (model_on) begin
            if (reset)                 eg = 0;
            else if (gpu_req && ext_req) eg = (m_wait < MX) ? 2 : 1;
            else if (gpu_req)          eg = 1;
            else if (ext_req)          eg = 2;
            else                       eg = 0;

            exp_a  = (eg == 2) ? ext_addr  : gpu_addr;
            exp_wd = (eg == 2) ? ext_wdata : gpu_wdata;
            exp_we = (eg == 2) ? ext_we : (eg == 1) ? gpu_we : 1'b0;

            chk("gpu_ack",    gpu_ack,    eg == 1);
            chk("ext_ack",    ext_ack,    eg == 2);
            chk("ramen",      ramen,      eg != 0);
            chk("ramwe",      ramwe,      exp_we);
            chk("rama",       rama,       exp_a);
            chk("ram_wdata",  ram_wdata,  exp_wd);
            chk("gpu_rvalid", gpu_rvalid, pend_g && !reset);
            chk("ext_rvalid", ext_rvalid, pend_e && !reset);
            if ((pend_g || pend_e) && !reset) chk("rdata", rdata, pend_data);

            pend_g = (eg == 1) && !gpu_we;
            pend_e = (eg == 2) && !ext_we;
            if (eg != 0) begin
                if (exp_we) m_mem[exp_a] = exp_wd;
                else        pend_data    = m_mem[exp_a];
            end

            if (reset || !gpu_req || eg == 1) m_wait = 0;
            else if (eg == 2 && m_wait < MX)  m_wait = m_wait + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gpu_set(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gpu_req = r; gpu_we = w; gpu_addr = a; gpu_wdata = d;
    endtask

    task automatic ext_set(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ext_req = r; ext_we = w; ext_addr = a; ext_wdata = d;
    endtask

    logic ga, ea;

    initial begin
        reset = 1'b1;
        gpu_set(1, 0, '0, '0);
        ext_set(1, 1, '0, '0);
        step();
        step();
        model_on = 1'b1;
        // reset forces grants off even with both ports requesting
        @(negedge clk);
        chk("rst_gpu_ack", gpu_ack, 0);
        chk("rst_ext_ack", ext_ack, 0);
        chk("rst_ramen",   ramen,   0);
        chk("rst_ramwe",   ramwe,   0);
        chk("rst_rvalid",  {gpu_rvalid, ext_rvalid}, 0);
        step();
        gpu_set(0, 0, '0, '0);
        ext_set(0, 0, '0, '0);
        reset = 1'b0;
        step();
        $display("tb: reset done");

        // GPU-only write then read of the top address
        gpu_set(1, 1, 10'h3FF, 32'h12345678);
        @(negedge clk); chk("t1_wr_ack", gpu_ack, 1);
        step();
        gpu_set(1, 0, 10'h3FF, 32'h0);
        @(negedge clk); chk("t1_rd_ack", gpu_ack, 1);
        step();
        gpu_set(0, 0, 10'h3FF, 32'h0);
        @(negedge clk);
        chk("t1_rvalid", gpu_rvalid, 1);
        chk("t1_rdata",  rdata, 32'h12345678);
        chk("t1_ext_rv", ext_rvalid, 0);
        step();
        $display("tb: gpu write/read 0x3ff");

        // simultaneous reads: external wins first
        gpu_set(1, 0, 10'h010, 32'h0);
        ext_set(1, 0, 10'h020, 32'h0);
        @(negedge clk); chk("t2_ext_first", ext_ack, 1); chk("t2_gpu_wait", gpu_ack, 0);
        step();
        ext_set(0, 0, 10'h020, 32'h0);
        @(negedge clk); chk("t2_gpu_next", gpu_ack, 1); chk("t2_ext_rv", ext_rvalid, 1); chk("t2_gpu_rv0", gpu_rvalid, 0);
        step();
        gpu_set(0, 0, 10'h010, 32'h0);
        @(negedge clk); chk("t2_gpu_rv", gpu_rvalid, 1); chk("t2_ext_rv0", ext_rvalid, 0);
        step();
        @(negedge clk); chk("t2_quiet", {gpu_rvalid, ext_rvalid}, 0);
        step();
        $display("tb: simultaneous reads");

        // starvation: MX external grants, then one GPU grant, three times
        gpu_set(1, 0, 10'h011, 32'h0);
        ext_set(1, 0, 10'h021, 32'h0);
        for (int i = 0; i < 3 * (MX + 1); i++) begin
            @(negedge clk);
            chk("t3_gpu_ack", gpu_ack, (i % (MX + 1)) == MX);
            chk("t3_ext_ack", ext_ack, (i % (MX + 1)) != MX);
            step();
        end
        gpu_set(0, 0, '0, '0);
        ext_set(0, 0, '0, '0);
        step();
        $display("tb: starvation pattern");

        // write/read hazard on the same address
        ext_set(1, 1, 10'h100, 32'hDEADBEEF);
        @(negedge clk); chk("t4_ext_ack", ext_ack, 1);
        step();
        ext_set(0, 0, '0, '0);
        gpu_set(1, 0, 10'h100, 32'h0);
        @(negedge clk); chk("t4_gpu_ack", gpu_ack, 1);
        step();
        gpu_set(0, 0, '0, '0);
        @(negedge clk); chk("t4_rv", gpu_rvalid, 1); chk("t4_rdata", rdata, 32'hDEADBEEF);
        step();
        $display("tb: write/read hazard");

        // reset in the cycle after a read grant
        gpu_set(1, 0, 10'h3FF, 32'h0);
        @(negedge clk); chk("t5_ack", gpu_ack, 1);
        step();
        reset = 1'b1;
        gpu_set(0, 0, '0, '0);
        ext_set(1, 0, 10'h005, 32'h0);
        @(negedge clk);
        chk("t5_rv_supp", gpu_rvalid, 0);
        chk("t5_ramen",   ramen, 0);
        chk("t5_acks",    {gpu_ack, ext_ack}, 0);
        step();
        reset = 1'b0;
        ext_set(0, 0, '0, '0);
        gpu_set(1, 0, 10'h3FF, 32'h0);
        @(negedge clk); chk("t5_post_ack", gpu_ack, 1);
        step();
        gpu_set(0, 0, '0, '0);
        @(negedge clk); chk("t5_post_rv", gpu_rvalid, 1); chk("t5_post_rd", rdata, 32'h12345678);
        step();
        $display("tb: reset mid-read");

        // withdrawal while losing clears the wait count
        gpu_set(1, 0, 10'h033, 32'h0);
        ext_set(1, 0, 10'h044, 32'h0);
        step();
        step();
        gpu_set(0, 0, 10'h033, 32'h0);
        @(negedge clk); chk("t6_no_ack", gpu_ack, 0); chk("t6_ext", ext_ack, 1);
        step();
        @(negedge clk); chk("t6_no_rv", gpu_rvalid, 0);
        gpu_set(1, 0, 10'h033, 32'h0);
        #1;
        for (int i = 0; i <= MX; i++) begin
            if (i > 0) @(negedge clk);
            chk("t6_restart", gpu_ack, i == MX);
            step();
        end
        gpu_set(0, 0, '0, '0);
        ext_set(0, 0, '0, '0);
        step();
        $display("tb: withdrawal");

        // randomized traffic, obeying the hold-until-ack rule
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ga = gpu_ack;
            ea = ext_ack;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            if (!(gpu_req && !ga && $urandom_range(0, 9) != 0))
                gpu_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), $urandom);
            if (!(ext_req && !ea && $urandom_range(0, 9) != 0))
                ext_set($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), $urandom);
        end
        gpu_set(0, 0, '0, '0);
        ext_set(0, 0, '0, '0);
        reset = 1'b0;
        step();
        step();
        $display("tb: random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
